// File: rtl/reg_alu_issue.sv
// reg_alu_issue: instruction queue and issue controller sitting directly upstream
// of reg_alu. Words enter through a valid/ready handshake and are buffered in a
// circular queue. They leave one per cycle on a registered bus, and a sticky
// carry flag is captured from reg_alu.
// Optional feature: define ISSUE_CNT_EN to add the 16-bit issue_cnt output.
`timescale 1ns/1ps
module reg_alu_issue #(
  parameter int DEPTH = 4,
  parameter int AW    = 3,
  parameter int DW    = 16,
  parameter int IW    = 4 + 3*AW + DW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     pause,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IW-1:0]            in_instr,
  output logic                     sel,
  output logic                     wr,
  output logic [1:0]               op,
  output logic [AW-1:0]            rd_addr_a,
  output logic [AW-1:0]            rd_addr_b,
  output logic [AW-1:0]            wr_addr,
  output logic [DW-1:0]            d_in,
  output logic                     issue_vld,
  input  logic                     cout,
  output logic                     carry_flag,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic [1:0]               state
`ifdef ISSUE_CNT_EN
  ,
  output logic [15:0]              issue_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  logic [IW-1:0] mem [DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          clr;
  logic [1:0]    state_nxt;
  logic [IW-1:0] bus_p1;
  logic          vld_p1;

  // The extra wrap bit on each pointer separates full from empty.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign q_count  = wr_ptr - rd_ptr;
  assign in_ready = !full && (state != S_FLUSH);

  // A flush request and the FLUSH state both wipe the queue and the carry.
  // A word offered in the same cycle as a flush is discarded.
  assign clr  = flush || (state == S_FLUSH);
  assign push = in_valid && in_ready && !clr;
  assign pop  = (state == S_RUN) && !empty && !pause && !flush;

  // Next-state logic; flush outranks pause, and pause outranks start.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_FLUSH;
    end else begin
      case (state)
        S_IDLE, S_PAUSE: if (start && !pause) state_nxt = S_RUN;
        S_RUN:           if (pause) state_nxt = S_PAUSE;
        default:         state_nxt = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Queue pointers; clearing on a flush takes priority over any push or pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  // Queue storage holds data only; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= in_instr;
  end

  // Issue stage: pop into the bus registers, or drive an all-zero bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_p1 <= '0;
      vld_p1 <= 1'b0;
    end else if (pop) begin
      bus_p1 <= mem[rd_ptr[PW-1:0]];
      vld_p1 <= 1'b1;
    end else begin
      bus_p1 <= '0;
      vld_p1 <= 1'b0;
    end
  end

  assign {sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in} = bus_p1;
  assign issue_vld = vld_p1;

  // Sticky carry: updated only by a real ALU write; a flush clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                          carry_flag <= 1'b0;
    else if (clr)                                        carry_flag <= 1'b0;
    else if (vld_p1 && bus_p1[IW-1] && bus_p1[IW-2])     carry_flag <= cout;
  end

`ifdef ISSUE_CNT_EN
  // Free-running count of issued words; wraps naturally and survives a flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      issue_cnt <= 16'd0;
    else if (vld_p1) issue_cnt <= issue_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_reg_alu_issue.sv
// tb_reg_alu_issue: directed-vector bench for reg_alu_issue.
// Define ISSUE_CNT_EN to cover the optional issue counter as well.
`timescale 1ns/1ps
module tb_reg_alu_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        pause;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [28:0] in_instr;
  logic        sel;
  logic        wr;
  logic [1:0]  op;
  logic [2:0]  rd_addr_a;
  logic [2:0]  rd_addr_b;
  logic [2:0]  wr_addr;
  logic [15:0] d_in;
  logic        issue_vld;
  logic        cout;
  logic        carry_flag;
  logic [2:0]  q_count;
  logic [1:0]  state;
`ifdef ISSUE_CNT_EN
  logic [15:0] issue_cnt;
`endif
  logic [28:0] bus;

  int vectors = 0;
  int miscompares = 0;

  logic [28:0] w [5] = '{29'h08001111, 29'h08122222, 29'h0a243333, 29'h0c364444, 29'h0e485555};

  reg_alu_issue dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .sel(sel), .wr(wr), .op(op), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .wr_addr(wr_addr), .d_in(d_in), .issue_vld(issue_vld), .cout(cout),
    .carry_flag(carry_flag), .q_count(q_count), .state(state)
`ifdef ISSUE_CNT_EN
    , .issue_cnt(issue_cnt)
`endif
  );

  assign bus = {sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in};

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; pause = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_instr = '0; cout = 1'b0;
    #2;
    vectors++;
    if ({in_ready, issue_vld, bus, state, q_count, carry_flag} !== {1'b1, 1'b0, 29'h0, 2'd0, 3'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_held: rdy=%b vld=%b bus=%h st=%0d q=%0d cf=%b, want 1 0 0 0 0 0",
               in_ready, issue_vld, bus, state, q_count, carry_flag);
    end
    #10.5 reset = 1'b1;
    step();
    vectors++;
    if ({in_ready, issue_vld, bus, state, q_count} !== {1'b1, 1'b0, 29'h0, 2'd0, 3'd0}) begin
      miscompares++;
      $display("FAIL reset_released: rdy=%b vld=%b bus=%h st=%0d q=%0d, want 1 0 0 0 0",
               in_ready, issue_vld, bus, state, q_count);
    end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_instr = 29'h0b7fcdef;
    step();
    in_valid = 1'b0;
    vectors++;
    if ({q_count, state, issue_vld} !== {3'd1, 2'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL single_queued: q=%0d st=%0d vld=%b, want 1 0 0", q_count, state, issue_vld);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    vectors++;
    if ({state, issue_vld} !== {2'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL single_run: st=%0d vld=%b, want 1 0", state, issue_vld);
    end
    step();
    vectors++;
    if ({issue_vld, bus} !== {1'b1, 29'h0b7fcdef}) begin
      miscompares++;
      $display("FAIL single_issue: vld=%b bus=%h, want 1 0b7fcdef", issue_vld, bus);
    end
    vectors++;
    if ({wr, d_in} !== {1'b1, 16'hcdef}) begin
      miscompares++;
      $display("FAIL single_fields: wr=%b d_in=%h, want 1 cdef", wr, d_in);
    end
    step();
    vectors++;
    if ({issue_vld, bus, q_count} !== {1'b0, 29'h0, 3'd0}) begin
      miscompares++;
      $display("FAIL single_bubble: vld=%b bus=%h q=%0d, want 0 0 0", issue_vld, bus, q_count);
    end
  endtask

  task automatic test_fill();
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    vectors++;
    if (state !== 2'd0) begin
      miscompares++;
      $display("FAIL fill_idle: st=%0d, want 0", state);
    end
    in_valid = 1'b1; in_instr = w[0];
    for (int n = 0; n < 4; n++) begin
      step();
      in_instr = w[n+1];
    end
    vectors++;
    if ({in_ready, q_count} !== {1'b0, 3'd4}) begin
      miscompares++;
      $display("FAIL fill_full: rdy=%b q=%0d, want 0 4", in_ready, q_count);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    vectors++;
    if ({q_count, issue_vld} !== {3'd4, 1'b0}) begin
      miscompares++;
      $display("FAIL fill_start: q=%0d vld=%b, want 4 0", q_count, issue_vld);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      vectors++;
      if ({issue_vld, bus} !== {1'b1, w[k]}) begin
        miscompares++;
        $display("FAIL fill_issue%0d: vld=%b bus=%h, want 1 %h", k, issue_vld, bus, w[k]);
      end
      if (k == 0) begin
        vectors++;
        if ({in_ready, q_count} !== {1'b1, 3'd3}) begin
          miscompares++;
          $display("FAIL fill_open: rdy=%b q=%0d, want 1 3", in_ready, q_count);
        end
      end
      if (k == 1) begin
        in_valid = 1'b0;
        vectors++;
        if (q_count !== 3'd3) begin
          miscompares++;
          $display("FAIL fill_pushpop: q=%0d, want 3", q_count);
        end
      end
    end
    step();
    vectors++;
    if ({issue_vld, bus, q_count} !== {1'b0, 29'h0, 3'd0}) begin
      miscompares++;
      $display("FAIL fill_drain: vld=%b bus=%h q=%0d, want 0 0 0", issue_vld, bus, q_count);
    end
  endtask

  task automatic test_carry();
    in_valid = 1'b1; in_instr = 29'h18000001;
    step();
    in_instr = 29'h08000002;
    step();
    in_valid = 1'b0; cout = 1'b1;
    step();
    cout = 1'b0;
    vectors++;
    if ({carry_flag, bus} !== {1'b1, 29'h08000002}) begin
      miscompares++;
      $display("FAIL carry_set: cf=%b bus=%h, want 1 08000002", carry_flag, bus);
    end
    step();
    vectors++;
    if ({carry_flag, issue_vld} !== {1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL carry_hold: cf=%b vld=%b, want 1 0", carry_flag, issue_vld);
    end
    pause = 1'b1;
    step();
    pause = 1'b0; in_valid = 1'b1; in_instr = 29'h08000003;
    step();
    in_instr = 29'h08000004;
    step();
    in_valid = 1'b0;
    vectors++;
    if ({q_count, state, carry_flag} !== {3'd2, 2'd2, 1'b1}) begin
      miscompares++;
      $display("FAIL carry_paused: q=%0d st=%0d cf=%b, want 2 2 1", q_count, state, carry_flag);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    vectors++;
    if ({state, q_count, carry_flag, in_ready, issue_vld} !== {2'd3, 3'd0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL carry_flush: st=%0d q=%0d cf=%b rdy=%b vld=%b, want 3 0 0 0 0",
               state, q_count, carry_flag, in_ready, issue_vld);
    end
    step();
    vectors++;
    if ({state, in_ready} !== {2'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL carry_postflush: st=%0d rdy=%b, want 0 1", state, in_ready);
    end
  endtask

  task automatic test_pause();
    in_valid = 1'b1; in_instr = 29'h105a1234;
    step();
    in_instr = 29'h0ea55678;
    step();
    in_valid = 1'b0; start = 1'b1;
    step();
    pause = 1'b1;
    step();
    vectors++;
    if ({state, issue_vld, q_count} !== {2'd2, 1'b0, 3'd2}) begin
      miscompares++;
      $display("FAIL pause_enter: st=%0d vld=%b q=%0d, want 2 0 2", state, issue_vld, q_count);
    end
    pause = 1'b0; start = 1'b0;
    step();
    vectors++;
    if ({state, issue_vld, q_count} !== {2'd2, 1'b0, 3'd2}) begin
      miscompares++;
      $display("FAIL pause_hold: st=%0d vld=%b q=%0d, want 2 0 2", state, issue_vld, q_count);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    vectors++;
    if ({state, issue_vld} !== {2'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL pause_resume: st=%0d vld=%b, want 1 0", state, issue_vld);
    end
    step();
    vectors++;
    if ({issue_vld, bus} !== {1'b1, 29'h105a1234}) begin
      miscompares++;
      $display("FAIL pause_head: vld=%b bus=%h, want 1 105a1234", issue_vld, bus);
    end
    step();
    vectors++;
    if ({issue_vld, bus} !== {1'b1, 29'h0ea55678}) begin
      miscompares++;
      $display("FAIL pause_second: vld=%b bus=%h, want 1 0ea55678", issue_vld, bus);
    end
    step();
    vectors++;
    if ({issue_vld, q_count} !== {1'b0, 3'd0}) begin
      miscompares++;
      $display("FAIL pause_drain: vld=%b q=%0d, want 0 0", issue_vld, q_count);
    end
`ifdef ISSUE_CNT_EN
    vectors++;
    if (issue_cnt !== 16'd10) begin
      miscompares++;
      $display("FAIL issue_cnt_total: cnt=%0d, want 10", issue_cnt);
    end
`endif
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; in_instr = 29'h08000aaa;
    step();
    in_instr = 29'h08000bbb;
    step();
    in_valid = 1'b0;
    vectors++;
    if ({issue_vld, q_count} !== {1'b1, 3'd1}) begin
      miscompares++;
      $display("FAIL areset_pre: vld=%b q=%0d, want 1 1", issue_vld, q_count);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({issue_vld, bus, q_count, state} !== {1'b0, 29'h0, 3'd0, 2'd0}) begin
      miscompares++;
      $display("FAIL areset_drop: vld=%b bus=%h q=%0d st=%0d, want 0 0 0 0",
               issue_vld, bus, q_count, state);
    end
`ifdef ISSUE_CNT_EN
    vectors++;
    if (issue_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL areset_cnt: cnt=%0d, want 0", issue_cnt);
    end
`endif
    #2 reset = 1'b1;
    step();
    vectors++;
    if ({in_ready, q_count, issue_vld, state} !== {1'b1, 3'd0, 1'b0, 2'd0}) begin
      miscompares++;
      $display("FAIL areset_release: rdy=%b q=%0d vld=%b st=%0d, want 1 0 0 0",
               in_ready, q_count, issue_vld, state);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_carry();
    test_pause();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
